// File: rtl/tw_gen_pkg.sv
// -----------------------------------------------------------------------------
// tw_gen_pkg
// Shared definitions for the twiddle-factor generator:
//   - default FFT size / word length / stage-select width
//   - quarter_cos(): constant function that builds the quarter-wave cosine table
//   - pos_one()/neg_one(): saturated +1.0 / -1.0 codes for a given word length
//   - clamp_stage(): limits a requested stage index to the last real stage
// -----------------------------------------------------------------------------
package tw_gen_pkg;

    localparam int LOG2N_DEF = 4;
    localparam int WL_DEF    = 10;
    localparam int SW_DEF    = 4;

    localparam real TW_PI = 3.14159265358979323846;

    // +1.0 cannot be represented in Q(WL, WL-1); it saturates one code below.
    function automatic int pos_one(input int wl);
        return (1 << (wl - 1)) - 1;
    endfunction

    // -1.0 is coded symmetrically with +1.0 so that negation is always exact.
    function automatic int neg_one(input int wl);
        return -pos_one(wl);
    endfunction

    // C[i] = round(cos(2*pi*i/N) * 2^(WL-1)), saturated at +1.0.
    // Only evaluated at elaboration time (i in 0..N/4, so cos is never negative).
    function automatic int quarter_cos(input int i, input int log2n, input int wl);
        real x;
        int  v;
        x = $cos(2.0 * TW_PI * real'(i) / real'(1 << log2n)) * real'(1 << (wl - 1));
        v = $rtoi(x + 0.5);
        if (v > pos_one(wl)) begin
            v = pos_one(wl);
        end
        return v;
    endfunction

    // Stages beyond the last one behave like the last stage (k = 0 always).
    function automatic int clamp_stage(input int s, input int log2n);
        return (s > log2n - 1) ? (log2n - 1) : s;
    endfunction

endpackage

// File: rtl/tw_qrom.sv
// -----------------------------------------------------------------------------
// tw_qrom
// Synchronous quarter-wave cosine ROM: N/4+1 entries of WL bits, one
// registered read port. Contents come from tw_gen_pkg::quarter_cos.
// Ports:
//   CLK     clock, rising edge
//   nRST    asynchronous active-low reset (clears the read register)
//   en_i    read enable; when low the read register holds its value
//   addr_i  read address, 0..N/4
//   data_o  registered table word (unsigned magnitude, MSB always 0)
// -----------------------------------------------------------------------------
module tw_qrom
    import tw_gen_pkg::*;
#(
    parameter int LOG2N = LOG2N_DEF,
    parameter int WL    = WL_DEF
) (
    input  logic               CLK,
    input  logic               nRST,
    input  logic               en_i,
    input  logic [LOG2N-2:0]   addr_i,
    output logic [WL-1:0]      data_o
);

    localparam int DEPTH = (1 << (LOG2N - 2)) + 1;

    logic [WL-1:0] rom [DEPTH];
    logic [WL-1:0] rd_q;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
        assign rom[gi] = WL'(quarter_cos(gi, LOG2N, WL));
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rd_q <= '0;
        end else if (en_i) begin
            rd_q <= rom[addr_i];
        end
    end

    assign data_o = rd_q;

endmodule

// File: rtl/tw_gen.sv
// -----------------------------------------------------------------------------
// tw_gen
// Pipelined twiddle-factor generator for an N-point radix-2 DIF SDF FFT stage.
// Each iVALID beat yields W = cos(2*pi*k/N) - j*sin(2*pi*k/N) (conjugated when
// inverse), with k = (cnt << stage) mod N/2, two cycles later.
// Ports:
//   CLK       clock, rising edge
//   nRST      asynchronous active-low reset
//   iSOF      start of frame, qualified by iVALID
//   iVALID    request one twiddle beat
//   iSTAGE    stage index, sampled on the SOF beat (clamped to LOG2N-1)
//   iINV      1 = inverse (conjugate), sampled on the SOF beat
//   oVALID    iVALID delayed by two cycles
//   oLAST     marks the beat whose counter was N/2-1
//   oDATA_RE  real part, two's complement Q(WL, WL-1)
//   oDATA_IM  imaginary part, two's complement Q(WL, WL-1)
// -----------------------------------------------------------------------------
module tw_gen
    import tw_gen_pkg::*;
#(
    parameter int LOG2N = LOG2N_DEF,
    parameter int WL    = WL_DEF,
    parameter int SW    = SW_DEF
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic            iSOF,
    input  logic            iVALID,
    input  logic [SW-1:0]   iSTAGE,
    input  logic            iINV,
    output logic            oVALID,
    output logic            oLAST,
    output logic [WL-1:0]   oDATA_RE,
    output logic [WL-1:0]   oDATA_IM
);

    localparam int CW = LOG2N - 1;                       // counter / k width
    localparam logic [CW:0] HALF = (CW + 1)'(1 << (LOG2N - 1));
    localparam logic [CW:0] QTR  = (CW + 1)'(1 << (LOG2N - 2));

    // Frame state
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [SW-1:0] stage_q, stage_d;
    logic          inv_q,   inv_d;

    // Values used by the current beat
    logic [CW-1:0] beat_cnt;
    logic [SW-1:0] beat_stage;
    logic          beat_inv;
    logic [CW-1:0] beat_k;
    logic          beat_quad;
    logic          beat_last;

    // P1 registers
    logic          p1_valid_q;
    logic          p1_last_q;
    logic [CW-1:0] p1_k_q;
    logic          p1_quad_q;
    logic          p1_inv_q;

    // P2 registers (table words live inside the ROM instances)
    logic          p2_valid_q;
    logic          p2_last_q;
    logic          neg_re_q;
    logic          neg_im_q;

    logic [CW-1:0] re_addr;
    logic [CW-1:0] im_addr;
    logic [WL-1:0] re_mag;
    logic [WL-1:0] im_mag;

    // ---------------------------------------------------------------------
    // Beat counter and frame parameters. A SOF beat always uses cnt = 0 and
    // the freshly sampled stage/inverse, even when it interrupts a frame.
    // ---------------------------------------------------------------------
    always_comb begin
        cnt_d      = cnt_q;
        stage_d    = stage_q;
        inv_d      = inv_q;
        beat_cnt   = cnt_q;
        beat_stage = stage_q;
        beat_inv   = inv_q;
        if (iVALID && iSOF) begin
            beat_cnt   = '0;
            beat_stage = SW'(clamp_stage(int'(iSTAGE), LOG2N));
            beat_inv   = iINV;
            stage_d    = beat_stage;
            inv_d      = beat_inv;
        end
        if (iVALID) begin
            // Natural CW-bit overflow gives the N/2-1 -> 0 wrap.
            cnt_d = beat_cnt + 1'b1;
        end
        // Truncation to CW bits is the mod N/2.
        beat_k    = beat_cnt << beat_stage;
        beat_quad = ({1'b0, beat_k} > QTR);
        beat_last = &beat_cnt;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt_q   <= '0;
            stage_q <= '0;
            inv_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            stage_q <= stage_d;
            inv_q   <= inv_d;
        end
    end

    // ---------------------------------------------------------------------
    // P1: index, quadrant flag, per-beat conjugate flag, valid/last.
    // ---------------------------------------------------------------------
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            p1_valid_q <= 1'b0;
            p1_last_q  <= 1'b0;
            p1_k_q     <= '0;
            p1_quad_q  <= 1'b0;
            p1_inv_q   <= 1'b0;
        end else begin
            p1_valid_q <= iVALID;
            p1_last_q  <= iVALID & beat_last;
            if (iVALID) begin
                p1_k_q    <= beat_k;
                p1_quad_q <= beat_quad;
                p1_inv_q  <= beat_inv;
            end
        end
    end

    // Quarter-wave folding:
    //   k <= N/4 : re =  C[k],       im = -C[N/4-k]
    //   k >  N/4 : re = -C[N/2-k],   im = -C[k-N/4]
    always_comb begin
        if (p1_quad_q) begin
            re_addr = CW'(HALF - {1'b0, p1_k_q});
            im_addr = CW'({1'b0, p1_k_q} - QTR);
        end else begin
            re_addr = p1_k_q;
            im_addr = CW'(QTR - {1'b0, p1_k_q});
        end
    end

    // ---------------------------------------------------------------------
    // P2: registered table reads plus the sign flags that go with them.
    // Both parts need a word in the same cycle, hence two ROM copies.
    // ---------------------------------------------------------------------
    tw_qrom #(
        .LOG2N (LOG2N),
        .WL    (WL)
    ) u_qrom_re (
        .CLK    (CLK),
        .nRST   (nRST),
        .en_i   (p1_valid_q),
        .addr_i (re_addr),
        .data_o (re_mag)
    );

    tw_qrom #(
        .LOG2N (LOG2N),
        .WL    (WL)
    ) u_qrom_im (
        .CLK    (CLK),
        .nRST   (nRST),
        .en_i   (p1_valid_q),
        .addr_i (im_addr),
        .data_o (im_mag)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            p2_valid_q <= 1'b0;
            p2_last_q  <= 1'b0;
            neg_re_q   <= 1'b0;
            neg_im_q   <= 1'b0;
        end else begin
            p2_valid_q <= p1_valid_q;
            p2_last_q  <= p1_last_q;
            if (p1_valid_q) begin
                neg_re_q <= p1_quad_q;
                // Forward imaginary part is always -sin; inverse conjugates it.
                neg_im_q <= ~p1_inv_q;
            end
        end
    end

    // Sign is applied to registered magnitudes. Magnitudes never reach
    // 2^(WL-1), so negation is exact, and reset (all zero) maps to zero.
    // Because ROM and sign registers only load on valid beats, idle cycles
    // hold the last twiddle.
    assign oDATA_RE = neg_re_q ? -re_mag : re_mag;
    assign oDATA_IM = neg_im_q ? -im_mag : im_mag;
    assign oVALID   = p2_valid_q;
    assign oLAST    = p2_last_q;

endmodule

// File: tb/tb_tw_gen.sv
// -----------------------------------------------------------------------------
// tb_tw_gen
// Scoreboard bench for tw_gen (LOG2N=4, WL=10). Expected twiddles are computed
// from cos/sin directly and queued when a beat is driven; they are popped when
// the bench expects oVALID (two cycles later) and compared against the outputs.
// -----------------------------------------------------------------------------
module tb_tw_gen;

    localparam int LOG2N = 4;
    localparam int WL    = 10;
    localparam int SW    = 4;
    localparam int N     = 1 << LOG2N;
    localparam int HALFN = N / 2;
    localparam int LIM   = (1 << (WL - 1)) - 1;

    logic            CLK = 1'b0;
    logic            nRST;
    logic            iSOF;
    logic            iVALID;
    logic [SW-1:0]   iSTAGE;
    logic            iINV;
    logic            oVALID;
    logic            oLAST;
    logic [WL-1:0]   oDATA_RE;
    logic [WL-1:0]   oDATA_IM;

    tw_gen #(
        .LOG2N (LOG2N),
        .WL    (WL),
        .SW    (SW)
    ) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iSOF     (iSOF),
        .iVALID   (iVALID),
        .iSTAGE   (iSTAGE),
        .iINV     (iINV),
        .oVALID   (oVALID),
        .oLAST    (oLAST),
        .oDATA_RE (oDATA_RE),
        .oDATA_IM (oDATA_IM)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [WL-1:0] re;
        logic [WL-1:0] im;
        logic          last;
    } exp_t;

    exp_t          exp_q[$];
    logic [WL-1:0] cap_re[$];
    logic [WL-1:0] cap_im[$];
    logic          cap_last[$];
    logic [WL-1:0] fwd_im[$];

    int            n_checks = 0;
    int            n_errors = 0;

    // Reference model state
    int            m_cnt   = 0;
    int            m_stage = 0;
    logic          m_inv   = 1'b0;

    // Bench-side delay line of driven iVALID
    logic          vd1 = 1'b0;
    logic          vd2 = 1'b0;
    logic [WL-1:0] last_re = '0;
    logic [WL-1:0] last_im = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, want);
        end
    endtask

    function automatic int rnd_sat(input real x);
        int v;
        if (x >= 0.0) v = $rtoi(x + 0.5);
        else          v = -$rtoi(-x + 0.5);
        if (v > LIM)  v = LIM;
        if (v < -LIM) v = -LIM;
        return v;
    endfunction

    task automatic model_beat(input logic sof, input int stg, input logic inv);
        exp_t e;
        int   k;
        real  ang;
        if (sof) begin
            m_cnt   = 0;
            m_stage = (stg > LOG2N - 1) ? LOG2N - 1 : stg;
            m_inv   = inv;
        end
        k      = (m_cnt << m_stage) % HALFN;
        ang    = 2.0 * 3.14159265358979 * real'(k) / real'(N);
        e.re   = WL'(rnd_sat($cos(ang) * real'(1 << (WL - 1))));
        e.im   = m_inv ? WL'(rnd_sat($sin(ang) * real'(1 << (WL - 1))))
                       : WL'(-rnd_sat($sin(ang) * real'(1 << (WL - 1))));
        e.last = (m_cnt == HALFN - 1);
        m_cnt  = (m_cnt + 1) % HALFN;
        exp_q.push_back(e);
    endtask

    // One clock cycle: drive at the negedge, check at the following negedge.
    task automatic step(input logic v, input logic sof, input int stg, input logic inv);
        exp_t e;
        iVALID = v;
        iSOF   = sof;
        iSTAGE = SW'(stg);
        iINV   = inv;
        if (v) model_beat(sof, stg, inv);
        @(posedge CLK);
        vd2 = vd1;
        vd1 = v;
        @(negedge CLK);
        chk("ovalid", {31'b0, oVALID}, {31'b0, vd2});
        if (vd2) begin
            chk("sb_nonempty", {31'b0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("re",   {22'b0, oDATA_RE}, {22'b0, e.re});
                chk("im",   {22'b0, oDATA_IM}, {22'b0, e.im});
                chk("last", {31'b0, oLAST},    {31'b0, e.last});
            end
            cap_re.push_back(oDATA_RE);
            cap_im.push_back(oDATA_IM);
            cap_last.push_back(oLAST);
            $display("beat re=%b im=%b last=%0d", oDATA_RE, oDATA_IM, oLAST);
        end else begin
            chk("hold_re",   {22'b0, oDATA_RE}, {22'b0, last_re});
            chk("hold_im",   {22'b0, oDATA_IM}, {22'b0, last_im});
            chk("idle_last", {31'b0, oLAST},    32'd0);
        end
        last_re = oDATA_RE;
        last_im = oDATA_IM;
    endtask

    task automatic clear_cap();
        cap_re.delete();
        cap_im.delete();
        cap_last.delete();
    endtask

    task automatic flush();
        step(1'b0, 1'b0, 0, 1'b0);
        step(1'b0, 1'b0, 0, 1'b0);
    endtask

    initial begin
        int            nlast;
        logic [WL-1:0] neg;

        nRST   = 1'b0;
        iSOF   = 1'b0;
        iVALID = 1'b0;
        iSTAGE = '0;
        iINV   = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_valid", {31'b0, oVALID}, 32'd0);
        chk("rst_last",  {31'b0, oLAST},  32'd0);
        chk("rst_re",    {22'b0, oDATA_RE}, 32'd0);
        chk("rst_im",    {22'b0, oDATA_IM}, 32'd0);
        nRST = 1'b1;
        @(negedge CLK);

        // 1: stage 0 forward, k = 0..7
        clear_cap();
        for (int i = 0; i < HALFN; i++) step(1'b1, i == 0, 0, 1'b0);
        flush();
        chk("t1_re1", {22'b0, cap_re[1]}, {22'b0, 10'b0111011001});
        chk("t1_im1", {22'b0, cap_im[1]}, {22'b0, 10'b1100111100});
        chk("t1_re4", {22'b0, cap_re[4]}, 32'd0);
        chk("t1_im4", {22'b0, cap_im[4]}, {22'b0, 10'b1000000001});
        chk("t1_last7", {31'b0, cap_last[7]}, 32'd1);
        fwd_im = cap_im;

        // 2: stage 1, k = 0,2,4,6,0,2,4,6
        clear_cap();
        for (int i = 0; i < HALFN; i++) step(1'b1, i == 0, 1, 1'b0);
        flush();
        chk("t2_re1", {22'b0, cap_re[1]}, {22'b0, 10'b0101101010});
        chk("t2_im1", {22'b0, cap_im[1]}, {22'b0, 10'b1010010110});
        chk("t2_re5", {22'b0, cap_re[5]}, {22'b0, 10'b0101101010});

        // 3: stage 9 clamps to the last stage, then explicit stage 3
        clear_cap();
        for (int i = 0; i < HALFN; i++) step(1'b1, i == 0, 9, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, i == 0, 3, 1'b0);
        flush();
        for (int i = 0; i < HALFN + 4; i += 3) begin
            chk("t3_re", {22'b0, cap_re[i]}, {22'b0, 10'b0111111111});
            chk("t3_im", {22'b0, cap_im[i]}, 32'd0);
        end

        // 4: inverse stage 0
        clear_cap();
        for (int i = 0; i < HALFN; i++) step(1'b1, i == 0, 0, 1'b1);
        flush();
        chk("t4_re3", {22'b0, cap_re[3]}, {22'b0, 10'b0011000100});
        chk("t4_im3", {22'b0, cap_im[3]}, {22'b0, 10'b0111011001});
        for (int i = 0; i < HALFN; i++) begin
            neg = -fwd_im[i];
            chk("t4_flip", {22'b0, cap_im[i]}, {22'b0, neg});
        end

        // 5: gapped beats, SOF re-asserted on beat 5 aborts the frame
        clear_cap();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, i == 0, 0, 1'b0);
            if (i % 2 == 1) step(1'b0, 1'b1, 2, 1'b1);  // SOF without valid is ignored
        end
        for (int i = 0; i < HALFN; i++) begin
            step(1'b1, i == 0, 0, 1'b0);
            if (i == 2) step(1'b0, 1'b0, 0, 1'b0);
        end
        flush();
        chk("t5_restart_re", {22'b0, cap_re[5]}, {22'b0, 10'b0111111111});
        chk("t5_beat6_re",   {22'b0, cap_re[6]}, {22'b0, 10'b0111011001});
        nlast = 0;
        foreach (cap_last[i]) if (cap_last[i]) nlast++;
        chk("t5_nlast", nlast, 32'd1);

        // 6: async reset mid-frame (stage 2, inverse), then beats without SOF
        clear_cap();
        for (int i = 0; i < 3; i++) step(1'b1, i == 0, 2, 1'b1);
        iVALID = 1'b0;
        iSOF   = 1'b0;
        #2 nRST = 1'b0;
        #1;
        chk("t6_valid", {31'b0, oVALID}, 32'd0);
        chk("t6_last",  {31'b0, oLAST},  32'd0);
        chk("t6_re",    {22'b0, oDATA_RE}, 32'd0);
        chk("t6_im",    {22'b0, oDATA_IM}, 32'd0);
        @(negedge CLK);
        nRST = 1'b1;
        exp_q.delete();
        vd1 = 1'b0;
        vd2 = 1'b0;
        last_re = '0;
        last_im = '0;
        m_cnt = 0;
        m_stage = 0;
        m_inv = 1'b0;
        clear_cap();
        step(1'b1, 1'b0, 0, 1'b0);
        step(1'b1, 1'b0, 0, 1'b0);
        flush();
        chk("t6_k0_re", {22'b0, cap_re[0]}, {22'b0, 10'b0111111111});
        chk("t6_k0_im", {22'b0, cap_im[0]}, 32'd0);
        chk("t6_k1_re", {22'b0, cap_re[1]}, {22'b0, 10'b0111011001});
        chk("t6_k1_im", {22'b0, cap_im[1]}, {22'b0, 10'b1100111100});
        chk("sb_drained", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
